// File: rtl/game_clock_timer.sv
// MM:SS game-clock countdown driven by the rising edges of an asynchronous slow clock,
// with start/stop/reload control, BCD digit outputs and a timed end-of-period buzzer.
module game_clock_timer #(
  parameter int START_MIN     = 12,
  parameter int START_SEC     = 0,
  parameter int TICKS_PER_SEC = 1,
  parameter int BUZZ_TICKS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_in,
  input  logic       start_stop,
  input  logic       load,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       buzzer
);

  // state   | meaning
  // IDLE    | preset loaded, waiting for start
  // RUNNING | counting down on prescaled ticks
  // PAUSED  | count and prescaler frozen
  // EXPIRED | reached 00:00, buzzer timed, waits for load
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] PRESET_MIN = 7'(START_MIN);
  localparam logic [5:0] PRESET_SEC = 6'(START_SEC);
  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] BUZZ_LAST  = 8'(BUZZ_TICKS - 1);

  state_t     state, state_nx;
  logic [6:0] minutes, min_nx;
  logic [5:0] seconds, sec_nx;
  logic [7:0] presc, presc_nx;
  logic [7:0] buzz_cnt, buzz_cnt_nx;
  logic       buzz_q, buzz_nx;
  logic       s1, s2, s3;
  logic       tick;
  logic       count_zero;
  logic [6:0] min_step;
  logic [5:0] sec_step;
  logic       step_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sclk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick       = s2 & ~s3;
  assign count_zero = (minutes == 7'd0) && (seconds == 6'd0);

  // Value the count takes after one game second elapses.
  always_comb begin
    min_step = minutes;
    sec_step = seconds;
    if (seconds != 6'd0) begin
      sec_step = seconds - 6'd1;
    end else if (minutes != 7'd0) begin
      sec_step = 6'd59;
      min_step = minutes - 7'd1;
    end
    step_zero = (min_step == 7'd0) && (sec_step == 6'd0);
  end

  always_comb begin
    state_nx    = state;
    min_nx      = minutes;
    sec_nx      = seconds;
    presc_nx    = presc;
    buzz_cnt_nx = buzz_cnt;
    buzz_nx     = buzz_q;
    if (load) begin
      state_nx    = IDLE;
      min_nx      = PRESET_MIN;
      sec_nx      = PRESET_SEC;
      presc_nx    = 8'd0;
      buzz_cnt_nx = 8'd0;
      buzz_nx     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_stop && !count_zero) begin
            state_nx = RUNNING;
            presc_nx = 8'd0;
          end
        end
        RUNNING: begin
          if (tick && presc == PRESC_LAST) begin
            presc_nx = 8'd0;
            min_nx   = min_step;
            sec_nx   = sec_step;
            if (step_zero) begin
              state_nx    = EXPIRED;
              buzz_nx     = 1'b1;
              buzz_cnt_nx = 8'd0;
            end else if (start_stop) begin
              state_nx = PAUSED;
            end
          end else begin
            if (tick) begin
              presc_nx = presc + 8'd1;
            end
            if (start_stop) begin
              state_nx = PAUSED;
            end
          end
        end
        PAUSED: begin
          if (start_stop) begin
            state_nx = RUNNING;
            presc_nx = 8'd0;
          end
        end
        EXPIRED: begin
          if (tick && buzz_q) begin
            if (buzz_cnt == BUZZ_LAST) begin
              buzz_nx = 1'b0;
            end else begin
              buzz_cnt_nx = buzz_cnt + 8'd1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      minutes  <= PRESET_MIN;
      seconds  <= PRESET_SEC;
      presc    <= 8'd0;
      buzz_cnt <= 8'd0;
      buzz_q   <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nx;
      minutes  <= min_nx;
      seconds  <= sec_nx;
      presc    <= presc_nx;
      buzz_cnt <= buzz_cnt_nx;
      buzz_q   <= buzz_nx;
      running  <= (state_nx == RUNNING);
      expired  <= (state_nx == EXPIRED);
    end
  end

  assign buzzer = buzz_q;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign {min_tens, min_ones} = to_bcd(minutes);
  assign {sec_tens, sec_ones} = to_bcd({1'b0, seconds});

endmodule

// File: tb/tb_game_clock_timer.sv
// Scoreboard bench for game_clock_timer: a seconds-remaining reference model predicts
// the outputs after every clk edge and a separate monitor compares them.
module tb_game_clock_timer;
  localparam int START_MIN = 12;
  localparam int START_SEC = 0;
  localparam int TPS       = 2;
  localparam int BUZZ      = 3;
  localparam int PRESET    = START_MIN * 60 + START_SEC;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic clk = 1'b0, reset = 1'b0, sclk_in = 1'b0, start_stop = 1'b0, load = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, expired, buzzer;

  game_clock_timer #(
    .START_MIN(START_MIN), .START_SEC(START_SEC),
    .TICKS_PER_SEC(TPS), .BUZZ_TICKS(BUZZ)
  ) dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .start_stop(start_stop), .load(load),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .expired(expired), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mt, mo, st, so;
    logic r, e, b;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0, errors = 0;
  int rise_cnt = 0;
  int p_ss = 0, p_ld = 0;

  int m_remain = PRESET, m_mode = M_IDLE, m_presc = 0, m_buzz = 0, m_seen = 0, m_pend = 0;

  function automatic snap_t model_snap();
    snap_t s;
    int mm, ss;
    mm   = m_remain / 60;
    ss   = m_remain % 60;
    s.mt = 4'(mm / 10);
    s.mo = 4'(mm % 10);
    s.st = 4'(ss / 10);
    s.so = 4'(ss % 10);
    s.r  = (m_mode == M_RUN);
    s.e  = (m_mode == M_EXP);
    s.b  = (m_buzz > 0);
    return s;
  endfunction

  // Reference model: a tick lands on the 3rd clk edge after each sclk_in rise.
  initial begin : model
    bit tk;
    forever begin
      @(posedge clk);
      tk = 1'b0;
      if (!reset) begin
        m_remain = PRESET; m_mode = M_IDLE; m_presc = 0; m_buzz = 0;
        m_pend = 0; m_seen = rise_cnt;
      end else begin
        if (rise_cnt != m_seen) begin
          m_seen = rise_cnt;
          m_pend = 3;
        end
        if (m_pend > 0) begin
          m_pend--;
          tk = (m_pend == 0);
        end
        if (load) begin
          m_remain = PRESET; m_mode = M_IDLE; m_presc = 0; m_buzz = 0;
        end else begin
          case (m_mode)
            M_IDLE: if (start_stop && m_remain > 0) begin m_mode = M_RUN; m_presc = 0; end
            M_RUN: begin
              if (tk) begin
                m_presc++;
                if (m_presc == TPS) begin m_presc = 0; m_remain--; end
              end
              if (m_remain == 0) begin m_mode = M_EXP; m_buzz = BUZZ; end
              else if (start_stop) m_mode = M_PAUSE;
            end
            M_PAUSE: if (start_stop) begin m_mode = M_RUN; m_presc = 0; end
            default: if (tk && m_buzz > 0) m_buzz--;
          endcase
        end
      end
      exp_q.push_back(model_snap());
    end
  end

  initial begin : monitor
    snap_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {min_tens, min_ones, sec_tens, sec_ones, running, expired, buzzer};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t got %0d%0d:%0d%0d run=%0b exp=%0b buzz=%0b want %0d%0d:%0d%0d run=%0b exp=%0b buzz=%0b",
                   $time, a.mt, a.mo, a.st, a.so, a.r, a.e, a.b, e.mt, e.mo, e.st, e.so, e.r, e.e, e.b);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_cycle();
    start_stop = (p_ss > 0) && ($urandom_range(p_ss - 1) == 0);
    load       = (p_ld > 0) && ($urandom_range(p_ld - 1) == 0);
    @(negedge clk);
    start_stop = 1'b0;
    load       = 1'b0;
  endtask

  task automatic sclk_edge(input int half);
    sclk_in = 1'b1;
    rise_cnt++;
    repeat (half) step_cycle();
    sclk_in = 1'b0;
    repeat (half) step_cycle();
  endtask

  task automatic pulse(input bit ss, input bit ld);
    start_stop = ss;
    load       = ld;
    @(negedge clk);
    start_stop = 1'b0;
    load       = 1'b0;
  endtask

  task automatic run_to_expiry();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 1500 && expired !== 1'b1; i++) sclk_edge(2);
    checks++;
    if (expired !== 1'b1) begin
      errors++;
      $display("FAIL expiry_timeout got expired=%0b want 1 within 1500 edges", expired);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    cyc(5);
    reset = 1'b1;
    cyc(2);
    repeat (10) sclk_edge(3);

    pulse(1'b1, 1'b0);
    repeat (2) sclk_edge(3);
    sclk_edge(3);
    pulse(1'b1, 1'b0);
    repeat (4) sclk_edge(3);
    pulse(1'b1, 1'b0);
    repeat (2) sclk_edge(3);

    sclk_edge(3);
    pulse(1'b1, 1'b1);
    cyc(3);

    // start_stop lands on the very clk edge that applies a second-step
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    sclk_edge(3);
    sclk_in = 1'b1;
    rise_cnt++;
    cyc(2);
    pulse(1'b1, 1'b0);
    cyc(2);
    sclk_in = 1'b0;
    cyc(3);

    p_ss = 10;
    p_ld = 80;
    pulse(1'b1, 1'b0);
    repeat (300) sclk_edge($urandom_range(2, 5));
    p_ss = 0;
    p_ld = 0;

    run_to_expiry();
    pulse(1'b1, 1'b0);
    repeat (4) sclk_edge(3);

    run_to_expiry();
    sclk_edge(3);
    pulse(1'b0, 1'b1);
    cyc(3);

    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (20) sclk_edge(3);
    cyc(4);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_running got %0b want 1", running);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== {4'(START_MIN / 10), 4'(START_MIN % 10),
                                                      4'(START_SEC / 10), 4'(START_SEC % 10)}
        || running !== 1'b0 || expired !== 1'b0 || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %0d%0d:%0d%0d run=%0b exp=%0b buzz=%0b want %0d%0d:%0d%0d run=0 exp=0 buzz=0",
               min_tens, min_ones, sec_tens, sec_ones, running, expired, buzzer,
               START_MIN / 10, START_MIN % 10, START_SEC / 10, START_SEC % 10);
    end
    cyc(3);
    reset = 1'b1;
    cyc(3);
    pulse(1'b1, 1'b0);
    repeat (3) sclk_edge(3);
    cyc(2);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_clock_timer.md
Name: game_clock_timer

Overview:
- Game-clock countdown engine for the basketball scoreboard.
- Consumes the toggling slow clock produced by the scoreboard's clock divider. It synchronizes that clock, detects its rising edges and counts down a MM:SS game clock.
- Provides start/stop/reload control, per-digit BCD outputs for the seven-segment driver, and a timed end-of-period buzzer.

Parameters:
- START_MIN, 12, preset minutes loaded at reset and on load (0-99)
- START_SEC, 0, preset seconds loaded at reset and on load (0-59)
- TICKS_PER_SEC, 1, slow-clock rising edges per game second (1-255)
- BUZZ_TICKS, 3, slow-clock rising edges the buzzer stays high after expiry (1-255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sclk_in  in  1  slow clock from the divider; treated as asynchronous level
- start_stop  in  1  single-clk pulse; toggles run/pause
- load  in  1  single-clk pulse; reloads preset and stops the clock
- min_tens  out  4  BCD minutes tens digit
- min_ones  out  4  BCD minutes ones digit
- sec_tens  out  4  BCD seconds tens digit (0-5)
- sec_ones  out  4  BCD seconds ones digit
- running  out  1  high in RUNNING state
- expired  out  1  high in EXPIRED state
- buzzer  out  1  end-of-period horn

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, minutes=START_MIN, seconds=START_SEC
  - prescaler=0, buzz counter=0
  - sync flops=0, running=0, expired=0, buzzer=0
  - BCD outputs reflect the preset.
- Reset asserted mid-countdown returns all of the above immediately.
- Tick generation:
  - sclk_in passes through sync flops s1 then s2; edge register s3 follows s2.
  - tick = s2 & ~s3, exactly one clk wide per sclk_in rising edge.
  - Counter update occurs on the 3rd clk rising edge after sclk_in rises (setup met).
  - Falling edges of sclk_in are ignored.
- Prescaler (counts 0..TICKS_PER_SEC-1):
  - Increments on each tick while RUNNING.
  - On the tick where prescaler==TICKS_PER_SEC-1, it wraps to 0 and a second-step occurs.
  - Cleared on load and on any IDLE/PAUSED->RUNNING transition.
- Second-step:
  - If seconds>0: seconds-1.
  - Else if minutes>0: seconds=59 and minutes-1.
  - A step that produces 00:00 moves the state to EXPIRED in the same cycle.
- BCD outputs are combinational from the minutes/seconds registers: tens=value/10, ones=value%10.
- States:
  - IDLE: start_stop -> RUNNING if the count is not 00:00; otherwise ignored.
  - RUNNING: start_stop -> PAUSED; a second-step reaching 00:00 -> EXPIRED.
  - PAUSED: start_stop -> RUNNING; ticks ignored, count frozen, prescaler frozen.
  - EXPIRED: start_stop ignored; only load leaves, -> IDLE.
- Buzzer:
  - On entry to EXPIRED, buzzer=1 and buzz counter=0.
  - The buzz counter increments per tick while buzzer=1.
  - buzzer drops on the tick where the counter reaches BUZZ_TICKS-1.
  - buzzer is never high outside EXPIRED.
- Simultaneous events:
  - load wins over start_stop and over tick: preset loaded, state=IDLE, buzzer=0.
  - start_stop pausing in the same cycle as a second-step tick: the step is applied, then the state is PAUSED.
  - A step reaching 00:00 together with start_stop: EXPIRED wins.
- Presets of 00:00: reset/load land in IDLE with the count at 00:00; start is ignored, and expired stays 0.
- running and expired are registered state decodes, valid the cycle after the transition.

Test Plan:
- Reset with defaults:
  - reset low for 5 clk, then high.
  - Expect min_tens=1, min_ones=2, sec_tens=0, sec_ones=0; running=0, expired=0, buzzer=0.
  - 10 sclk_in edges applied while IDLE leave the count at 12:00.
- Countdown wrap (START_MIN=1, START_SEC=1):
  - Pulse start_stop, then apply 2 sclk_in rising edges.
  - Expect 01:00, then 00:59 (sec_tens=5, sec_ones=9, min_ones=0).
  - Each change occurs 3 clk after the sclk_in rise.
- Expiry and buzzer (START_MIN=0, START_SEC=2, BUZZ_TICKS=3):
  - start_stop, then 2 edges: 00:00 with expired=1, buzzer=1, running=0.
  - buzzer stays high through 2 more edges and drops on the 3rd.
  - A start_stop while EXPIRED has no effect.
- Pause/resume (TICKS_PER_SEC=2):
  - Run, give 1 edge (prescaler=1), pause, give 4 edges: count unchanged.
  - Resume (prescaler cleared): 2 edges decrement exactly one second.
- Simultaneous events:
  - load and start_stop in the same cycle while RUNNING at 05:17 -> 12:00, IDLE.
  - load during buzzer=1 -> buzzer=0 next cycle, expired=0.
- Asynchronous reset mid-run:
  - reset pulled low between clk edges at 03:45 RUNNING.
  - Outputs return to 12:00, running=0 before the next clk edge.
